// File: rtl/riscv_rs_pkg.sv
// Shared types and constants for the multi-CDB ALU reservation station.
// Optional feature macro: RS_AGE_ORDER_EN (adds a per-entry dispatch sequence number).
package riscv_rs_pkg;
  localparam int RS_ROB_IDX_W = 4;
  localparam int RS_XLEN      = 32;
  localparam int RS_DEPTH_D   = 16;
  // Sequence width is one bit wider than the index so live entries never alias.
  localparam int RS_SEQ_W     = $clog2(RS_DEPTH_D) + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // One station slot; widths follow the package defaults.
  typedef struct packed {
    logic                    valid;
    logic                    q1_need;
    logic                    q2_need;
    logic [RS_ROB_IDX_W-1:0] q1;
    logic [RS_ROB_IDX_W-1:0] q2;
    logic [RS_XLEN-1:0]      v1;
    logic [RS_XLEN-1:0]      v2;
    logic [RS_XLEN-1:0]      pc;
    logic [RS_XLEN-1:0]      imm;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic                    funct7b;
    logic [RS_ROB_IDX_W-1:0] rob;
`ifdef RS_AGE_ORDER_EN
    logic [RS_SEQ_W-1:0]     seq;
`endif
  } rs_entry_t;
endpackage

// File: rtl/rs_select.sv
// Issue selector: picks one ready entry.
// RS_AGE_ORDER_EN: oldest by wrap-safe sequence compare; otherwise lowest index.
module rs_select #(
  parameter int DEPTH = 16
`ifdef RS_AGE_ORDER_EN
  , parameter int SEQ_W = $clog2(DEPTH) + 1
`endif
) (
  input  logic [DEPTH-1:0]              ready,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][SEQ_W-1:0]   seq,
`endif
  output logic                          sel_valid,
  output logic [$clog2(DEPTH)-1:0]      sel_idx
);
  localparam int IW = $clog2(DEPTH);

`ifdef RS_AGE_ORDER_EN
  logic [SEQ_W-1:0] w_best, w_diff;

  // Linear scan keeping the oldest ready entry; a negative modular difference means older.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    w_best    = '0;
    w_diff    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_diff = seq[i] - w_best;
      if (ready[i] && (!sel_valid || w_diff[SEQ_W-1])) begin
        sel_valid = 1'b1;
        sel_idx   = i[IW-1:0];
        w_best    = seq[i];
      end
    end
  end
`else
  // Fixed priority: scanning downwards lets the lowest ready index win.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = i[IW-1:0];
      end
    end
  end
`endif
endmodule

// File: rtl/reservation_station_multi.sv
// ALU reservation station snooping CDB_NUM broadcast channels.
// Optional feature macro: RS_AGE_ORDER_EN (oldest-ready issue instead of lowest index).
module reservation_station_multi import riscv_rs_pkg::*; #(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_IDX_W = RS_ROB_IDX_W,
  parameter int XLEN      = RS_XLEN,
  parameter int CDB_NUM   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rdy,
  input  logic                         rollback,
  input  logic                         in_valid,
  input  logic [XLEN-1:0]              in_value_1,
  input  logic [XLEN-1:0]              in_value_2,
  input  logic [ROB_IDX_W-1:0]         in_Q1,
  input  logic [ROB_IDX_W-1:0]         in_Q2,
  input  logic                         in_Q1_need,
  input  logic                         in_Q2_need,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_imm,
  input  logic [6:0]                   in_opcode,
  input  logic [2:0]                   in_funct3,
  input  logic                         in_funct7b,
  input  logic [ROB_IDX_W-1:0]         in_rob_entry,
  output logic                         full,
  output logic [$clog2(RS_DEPTH):0]    count,
  input  logic [CDB_NUM-1:0]           cdb_valid,
  input  logic [CDB_NUM*ROB_IDX_W-1:0] cdb_rob,
  input  logic [CDB_NUM*XLEN-1:0]      cdb_val,
  input  logic                         issue_stall,
  output logic                         out_valid,
  output logic [XLEN-1:0]              out_value_1,
  output logic [XLEN-1:0]              out_value_2,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_imm,
  output logic [6:0]                   out_opcode,
  output logic [2:0]                   out_funct3,
  output logic                         out_funct7b,
  output logic [ROB_IDX_W-1:0]         out_rob_entry
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;

  rs_entry_t        r_ent [RS_DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;
`ifdef RS_AGE_ORDER_EN
  logic [RS_SEQ_W-1:0]                   r_seq;
  logic [RS_DEPTH-1:0][RS_SEQ_W-1:0]     w_seq;
`endif

  logic [RS_DEPTH-1:0] w_ready;
  logic                w_sel_valid, w_issue, w_accept, w_free_vld;
  logic [IW-1:0]       w_sel_idx, w_free_idx;
  logic [CW-1:0]       w_cnt_nxt;
  rs_entry_t           w_new;

  assign count = r_count;
  assign full  = r_full;

  // Ready vector and lowest free slot, both from registered state only.
  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      w_ready[i] = r_ent[i].valid & ~r_ent[i].q1_need & ~r_ent[i].q2_need;
      if (!r_ent[i].valid) begin
        w_free_vld = 1'b1;
        w_free_idx = i[IW-1:0];
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Flatten sequence numbers for the selector.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) w_seq[i] = r_ent[i].seq;
  end
`endif

  rs_select #(
    .DEPTH (RS_DEPTH)
`ifdef RS_AGE_ORDER_EN
    , .SEQ_W (RS_SEQ_W)
`endif
  ) u_sel (
    .ready     (w_ready),
`ifdef RS_AGE_ORDER_EN
    .seq       (w_seq),
`endif
    .sel_valid (w_sel_valid),
    .sel_idx   (w_sel_idx)
  );

  assign w_issue   = w_sel_valid & ~issue_stall;
  assign w_accept  = in_valid & ~r_full & w_free_vld;
  assign w_cnt_nxt = r_count + CW'(w_accept) - CW'(w_issue);

  // New entry with same-cycle CDB capture; downward scan makes the lowest channel win.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.q1_need = in_Q1_need;
    w_new.q2_need = in_Q2_need;
    w_new.q1      = in_Q1;
    w_new.q2      = in_Q2;
    w_new.v1      = in_value_1;
    w_new.v2      = in_value_2;
    w_new.pc      = in_pc;
    w_new.imm     = in_imm;
    w_new.opcode  = in_opcode;
    w_new.funct3  = in_funct3;
    w_new.funct7b = in_funct7b;
    w_new.rob     = in_rob_entry;
`ifdef RS_AGE_ORDER_EN
    w_new.seq     = r_seq;
`endif
    for (int c = CDB_NUM-1; c >= 0; c--) begin
      if (in_Q1_need && cdb_valid[c] && cdb_rob[c*ROB_IDX_W +: ROB_IDX_W] == in_Q1) begin
        w_new.v1      = cdb_val[c*XLEN +: XLEN];
        w_new.q1_need = 1'b0;
      end
      if (in_Q2_need && cdb_valid[c] && cdb_rob[c*ROB_IDX_W +: ROB_IDX_W] == in_Q2) begin
        w_new.v2      = cdb_val[c*XLEN +: XLEN];
        w_new.q2_need = 1'b0;
      end
    end
  end

  // Entry state, wakeup, issue register and occupancy; everything frozen while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      out_valid     <= 1'b0;
      out_value_1   <= '0;
      out_value_2   <= '0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7b   <= 1'b0;
      out_rob_entry <= '0;
`ifdef RS_AGE_ORDER_EN
      r_seq         <= '0;
`endif
    end else if (rdy) begin
      if (rollback) begin
        for (int i = 0; i < RS_DEPTH; i++) r_ent[i].valid <= 1'b0;
        r_count   <= '0;
        r_full    <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          for (int c = CDB_NUM-1; c >= 0; c--) begin
            if (r_ent[i].valid && cdb_valid[c]) begin
              if (r_ent[i].q1_need && cdb_rob[c*ROB_IDX_W +: ROB_IDX_W] == r_ent[i].q1) begin
                r_ent[i].v1      <= cdb_val[c*XLEN +: XLEN];
                r_ent[i].q1_need <= 1'b0;
              end
              if (r_ent[i].q2_need && cdb_rob[c*ROB_IDX_W +: ROB_IDX_W] == r_ent[i].q2) begin
                r_ent[i].v2      <= cdb_val[c*XLEN +: XLEN];
                r_ent[i].q2_need <= 1'b0;
              end
            end
          end
        end
        out_valid <= w_issue;
        if (w_issue) begin
          out_value_1            <= r_ent[w_sel_idx].v1;
          out_value_2            <= r_ent[w_sel_idx].v2;
          out_pc                 <= r_ent[w_sel_idx].pc;
          out_imm                <= r_ent[w_sel_idx].imm;
          out_opcode             <= r_ent[w_sel_idx].opcode;
          out_funct3             <= r_ent[w_sel_idx].funct3;
          out_funct7b            <= r_ent[w_sel_idx].funct7b;
          out_rob_entry          <= r_ent[w_sel_idx].rob;
          r_ent[w_sel_idx].valid <= 1'b0;
        end
        // The target slot is free in registered state, so it never collides with the issued one.
        if (w_accept) begin
          r_ent[w_free_idx] <= w_new;
`ifdef RS_AGE_ORDER_EN
          r_seq             <= r_seq + 1'b1;
`endif
        end
        r_count <= w_cnt_nxt;
        r_full  <= (w_cnt_nxt == CW'(RS_DEPTH));
      end
    end
  end
endmodule

// File: tb/tb_reservation_station_multi.sv
// Scoreboard bench for reservation_station_multi; honours RS_AGE_ORDER_EN for issue order.
module tb_reservation_station_multi;
  import riscv_rs_pkg::*;
  localparam int D = 16, RW = 4, XL = 32, CN = 2;

  logic clk, rst_n, rdy, rollback, in_valid;
  logic [XL-1:0] in_value_1, in_value_2, in_pc, in_imm;
  logic [RW-1:0] in_Q1, in_Q2, in_rob_entry;
  logic in_Q1_need, in_Q2_need, in_funct7b;
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic full;
  logic [$clog2(D):0] count;
  logic [CN-1:0] cdb_valid;
  logic [CN*RW-1:0] cdb_rob;
  logic [CN*XL-1:0] cdb_val;
  logic issue_stall, out_valid, out_funct7b;
  logic [XL-1:0] out_value_1, out_value_2, out_pc, out_imm;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic [RW-1:0] out_rob_entry;

  reservation_station_multi #(.RS_DEPTH(D), .ROB_IDX_W(RW), .XLEN(XL), .CDB_NUM(CN)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .in_valid(in_valid),
    .in_value_1(in_value_1), .in_value_2(in_value_2), .in_Q1(in_Q1), .in_Q2(in_Q2),
    .in_Q1_need(in_Q1_need), .in_Q2_need(in_Q2_need), .in_pc(in_pc), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b(in_funct7b),
    .in_rob_entry(in_rob_entry), .full(full), .count(count), .cdb_valid(cdb_valid),
    .cdb_rob(cdb_rob), .cdb_val(cdb_val), .issue_stall(issue_stall), .out_valid(out_valid),
    .out_value_1(out_value_1), .out_value_2(out_value_2), .out_pc(out_pc), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b(out_funct7b),
    .out_rob_entry(out_rob_entry));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] v1, v2, pc; logic [3:0] rob; } exp_t;
  exp_t q[$];
  int n_checks = 0, n_errors = 0;

  // Issue monitor: every out_valid pulse must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL issue_unexpected: got rob %0d v1 %h, required no issue", out_rob_entry, out_value_1);
      end else begin
        e = q.pop_front();
        if (out_value_1 !== e.v1 || out_value_2 !== e.v2 || out_rob_entry !== e.rob || out_pc !== e.pc) begin
          n_errors++;
          $display("FAIL issue_data: got v1=%h v2=%h pc=%h rob=%0d, required v1=%h v2=%h pc=%h rob=%0d",
                   out_value_1, out_value_2, out_pc, out_rob_entry, e.v1, e.v2, e.pc, e.rob);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; cdb_valid = '0; cdb_rob = '0; cdb_val = '0; rollback = 0;
  endtask

  task automatic disp(input logic [31:0] v1, v2, input logic n1, n2,
                      input logic [3:0] q1, q2, rob, input logic [31:0] pc);
    in_valid = 1; in_value_1 = v1; in_value_2 = v2; in_Q1_need = n1; in_Q2_need = n2;
    in_Q1 = q1; in_Q2 = q2; in_rob_entry = rob; in_pc = pc; in_imm = pc ^ 32'h5;
    in_opcode = OPC_OP; in_funct3 = 3'd0; in_funct7b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 0; rdy = 1; issue_stall = 0; idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    #12;
    n_checks += 5;
    if (count !== 0)         begin n_errors++; $display("FAIL reset_count: got %0d, required 0", count); end
    if (full !== 0)          begin n_errors++; $display("FAIL reset_full: got %b, required 0", full); end
    if (out_valid !== 0)     begin n_errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_value_1 !== 0)   begin n_errors++; $display("FAIL reset_out_value_1: got %h, required 0", out_value_1); end
    if (out_rob_entry !== 0) begin n_errors++; $display("FAIL reset_out_rob: got %0d, required 0", out_rob_entry); end
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_rdy_freeze();
    rdy = 0;
    disp(32'h1, 32'h2, 0, 0, 0, 0, 4'd2, 32'h50);
    tick(); tick();
    n_checks += 2;
    if (count !== 0)     begin n_errors++; $display("FAIL rdy_count: got %0d, required 0", count); end
    if (out_valid !== 0) begin n_errors++; $display("FAIL rdy_out_valid: got %b, required 0", out_valid); end
    in_valid = 0; rdy = 1;
    tick();
  endtask

  task automatic test_ready_dispatch();
    disp(5, 7, 0, 0, 0, 0, 4'd3, 32'h100);
    q.push_back('{v1: 5, v2: 7, pc: 32'h100, rob: 4'd3});
    tick(); in_valid = 0;
    n_checks += 2;
    if (count !== 1)     begin n_errors++; $display("FAIL ready_count1: got %0d, required 1", count); end
    if (out_valid !== 0) begin n_errors++; $display("FAIL ready_early: got %b, required 0", out_valid); end
    tick();
    n_checks += 2;
    if (out_valid !== 1) begin n_errors++; $display("FAIL ready_issue: got %b, required 1", out_valid); end
    if (count !== 0)     begin n_errors++; $display("FAIL ready_count0: got %0d, required 0", count); end
  endtask

  task automatic test_wakeup();
    disp(0, 11, 1, 0, 4'd6, 0, 4'd4, 32'h200);
    q.push_back('{v1: 32'hDEAD, v2: 11, pc: 32'h200, rob: 4'd4});
    tick(); in_valid = 0;
    tick();
    cdb_valid = 2'b10; cdb_rob = {4'd6, 4'd0}; cdb_val = {32'hDEAD, 32'h0};
    tick(); idle();
    n_checks++;
    if (out_valid !== 0) begin n_errors++; $display("FAIL wakeup_early: got %b, required 0", out_valid); end
    tick();
    n_checks += 2;
    if (out_valid !== 1) begin n_errors++; $display("FAIL wakeup_issue: got %b, required 1", out_valid); end
    if (count !== 0)     begin n_errors++; $display("FAIL wakeup_count: got %0d, required 0", count); end
  endtask

  task automatic test_capture();
    disp(1, 0, 0, 1, 0, 4'd9, 4'd5, 32'h300);
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd9}; cdb_val = {32'h0, 32'd42};
    q.push_back('{v1: 1, v2: 42, pc: 32'h300, rob: 4'd5});
    tick(); idle();
    n_checks++;
    if (count !== 1) begin n_errors++; $display("FAIL capture_count: got %0d, required 1", count); end
    tick();
    n_checks++;
    if (out_valid !== 1) begin n_errors++; $display("FAIL capture_issue: got %b, required 1", out_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      disp(0, 100 + i, 1, 0, (i == 0) ? 4'd7 : 4'd8, 0, 4'(i), 32'h400 + i);
      tick();
    end
    in_valid = 0;
    n_checks += 2;
    if (count !== 16) begin n_errors++; $display("FAIL full_count: got %0d, required 16", count); end
    if (full !== 1)   begin n_errors++; $display("FAIL full_flag: got %b, required 1", full); end
    disp(32'h9, 32'h9, 0, 0, 0, 0, 4'd15, 32'h999);
    tick(); in_valid = 0;
    n_checks++;
    if (count !== 16) begin n_errors++; $display("FAIL full_ignore: got %0d, required 16", count); end
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd7}; cdb_val = {32'h0, 32'h77};
    q.push_back('{v1: 32'h77, v2: 100, pc: 32'h400, rob: 4'd0});
    tick(); idle();
    tick();
    n_checks += 3;
    if (out_valid !== 1) begin n_errors++; $display("FAIL full_issue: got %b, required 1", out_valid); end
    if (count !== 15)    begin n_errors++; $display("FAIL full_count15: got %0d, required 15", count); end
    if (full !== 0)      begin n_errors++; $display("FAIL full_clear: got %b, required 0", full); end
    cdb_valid = 2'b10; cdb_rob = {4'd8, 4'd0}; cdb_val = {32'h88, 32'h0};
    for (int i = 1; i < 16; i++) q.push_back('{v1: 32'h88, v2: 100 + i, pc: 32'h400 + i, rob: 4'(i)});
    tick(); idle();
    for (int k = 0; k < 40 && count != 0; k++) tick();
    n_checks++;
    if (count !== 0) begin n_errors++; $display("FAIL full_drain: got %0d, required 0", count); end
    tick();
  endtask

  task automatic test_stall();
    issue_stall = 1;
    disp(32'hA0, 32'hA1, 0, 0, 0, 0, 4'd1, 32'h500); tick();
    disp(32'hB0, 32'hB1, 0, 0, 0, 0, 4'd2, 32'h510); tick();
    in_valid = 0; issue_stall = 0;
    q.push_back('{v1: 32'hA0, v2: 32'hA1, pc: 32'h500, rob: 4'd1});
    tick();
    n_checks++;
    if (out_valid !== 1) begin n_errors++; $display("FAIL stall_first: got %b, required 1", out_valid); end
    issue_stall = 1;
    disp(32'hC0, 32'hC1, 0, 0, 0, 0, 4'd3, 32'h520); tick();
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 0) begin n_errors++; $display("FAIL stall_hold%0d: got %b, required 0", k, out_valid); end
    end
`ifdef RS_AGE_ORDER_EN
    q.push_back('{v1: 32'hB0, v2: 32'hB1, pc: 32'h510, rob: 4'd2});
    q.push_back('{v1: 32'hC0, v2: 32'hC1, pc: 32'h520, rob: 4'd3});
`else
    q.push_back('{v1: 32'hC0, v2: 32'hC1, pc: 32'h520, rob: 4'd3});
    q.push_back('{v1: 32'hB0, v2: 32'hB1, pc: 32'h510, rob: 4'd2});
`endif
    issue_stall = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1) begin n_errors++; $display("FAIL stall_release%0d: got %b, required 1", k, out_valid); end
    end
    tick();
    n_checks++;
    if (count !== 0) begin n_errors++; $display("FAIL stall_count: got %0d, required 0", count); end
  endtask

  task automatic test_rollback();
    for (int i = 0; i < 5; i++) begin
      disp(0, 32'h70 + i, 1, 0, 4'd12, 0, 4'(i), 32'h700 + i);
      tick();
    end
    disp(32'h1, 32'h2, 0, 0, 0, 0, 4'd9, 32'h7FF);
    rollback = 1;
    tick(); idle();
    n_checks += 2;
    if (count !== 0)     begin n_errors++; $display("FAIL rollback_count: got %0d, required 0", count); end
    if (out_valid !== 0) begin n_errors++; $display("FAIL rollback_valid: got %b, required 0", out_valid); end
    cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd12}; cdb_val = {32'h0, 32'h12};
    tick(); idle();
    repeat (4) tick();
    n_checks++;
    if (count !== 0) begin n_errors++; $display("FAIL rollback_after: got %0d, required 0", count); end
  endtask

  task automatic test_async_reset();
    disp(32'h11, 32'h22, 0, 0, 0, 0, 4'd7, 32'h600);
    q.push_back('{v1: 32'h11, v2: 32'h22, pc: 32'h600, rob: 4'd7});
    tick(); in_valid = 0;
    tick();
    n_checks++;
    if (out_valid !== 1) begin n_errors++; $display("FAIL areset_pre: got %b, required 1", out_valid); end
    #2 rst_n = 0;
    #1;
    n_checks += 4;
    if (out_valid !== 0)     begin n_errors++; $display("FAIL areset_valid: got %b, required 0", out_valid); end
    if (out_value_1 !== 0)   begin n_errors++; $display("FAIL areset_v1: got %h, required 0", out_value_1); end
    if (out_value_2 !== 0)   begin n_errors++; $display("FAIL areset_v2: got %h, required 0", out_value_2); end
    if (out_rob_entry !== 0) begin n_errors++; $display("FAIL areset_rob: got %0d, required 0", out_rob_entry); end
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_rdy_freeze();
    test_ready_dispatch();
    test_wakeup();
    test_capture();
    test_full();
    test_stall();
    test_rollback();
    test_async_reset();
    n_checks++;
    if (q.size() != 0) begin n_errors++; $display("FAIL scoreboard_left: got %0d pending, required 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
